led_scanner_pwm: RTL and testbench
==================================

Name: led_scanner_pwm

Overview:
Parametrised LED light-scanner driving N_LEDS outputs through per-LED PWM. It offers a configurable tail, four motion modes, debounced pause/faster/slower buttons and an 8-level speed divider. It sits directly behind the top-level pin wrapper: buttons come from ui_in and led_out goes to uo_out.

Parameters:
N_LEDS, 8, number of LED outputs (2..32); POS_W = clog2(N_LEDS).
PWM_BITS, 8, PWM counter and brightness width; FULL = 2^PWM_BITS-1.
DIV_BITS, 35, speed accumulator width.
SPEED_SHIFT, 10, step exponent at speed level 0.
TAIL, 2, tail length in LEDs (0..3).
DEBOUNCE_BITS, 18, debounce window = 2^DEBOUNCE_BITS cycles.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
btn_pause  in  1  raw pause/run button, async
btn_faster  in  1  raw speed-up button, async
btn_slower  in  1  raw speed-down button, async
mode  in  2  00 bounce, 01 wrap-up, 10 wrap-down, 11 fill-bar
led_out  out  N_LEDS  PWM LED drive, registered
pos_out  out  POS_W  current head position
speed_out  out  3  current speed level
paused_out  out  1  1 = paused

Behaviour:
- Reset is async. On reset: led_out=0, pos=0, dir=up, speed=3, paused=1, pwm_counter=0, accumulator=0, debounced states=0.
- Inputs: each raw button passes a 2-FF synchroniser, then the debouncer. The debounced state takes the synchronised value only after that value has differed from it for 2^DEBOUNCE_BITS consecutive cycles; any match restarts the count. A rising edge of the debounced state gives a 1-cycle pulse.
- Speed:
  - faster pulse: speed+1, saturating at 7.
  - slower pulse: speed-1, saturating at 0.
  - Both pulses in the same cycle: no change.
- Pause: a pause pulse toggles paused.
- Divider:
  - acc <= acc + (1 << (speed+SPEED_SHIFT)), DIV_BITS wide. It runs regardless of pause.
  - tick = carry-out of that addition, so the period is 2^(DIV_BITS-SPEED_SHIFT-speed) cycles.
  - A speed change affects the step from the next cycle; acc is not cleared.
- Motion: pos/dir update only on tick && !paused, using the mode sampled that cycle.
  - Bounce: dir=up and pos=N-1 gives dir<=down, pos<=N-2. dir=down and pos=0 gives dir<=up, pos<=1. Otherwise pos moves one step in dir. Endpoints are visited once per sweep.
  - Wrap-up: pos <= (pos==N-1) ? 0 : pos+1; dir<=up.
  - Wrap-down: pos <= (pos==0) ? N-1 : pos-1; dir<=down.
  - Fill-bar: same as wrap-up.
  - A mode change takes effect at the next tick with no reset of pos. An out-of-range pos cannot occur.
- Brightness, per LED i (combinational):
  - Bounce: d=|i-pos|; d=0 gives FULL; 1<=d<=TAIL gives FULL>>(2d); else 0.
  - Wrap modes: the tail is only behind the head, modulo N (wrap-up: i=(pos-d) mod N; wrap-down: i=(pos+d) mod N), with the same values.
  - Fill-bar: i<=pos gives FULL, else 0.
  - TAIL=0 means a head only.
- PWM:
  - pwm_counter increments every cycle and wraps.
  - led_out[i] <= (pwm_counter < brightness[i]), registered with 1-cycle latency.
  - FULL is on for 2^PWM_BITS-1 of 2^PWM_BITS cycles; 0 is never on.
- Status outputs: pos_out, speed_out and paused_out are direct register copies.

Decomposition:
- Package led_scanner_pkg:
  - mode encoding constants: MODE_BOUNCE, MODE_WRAP_UP, MODE_WRAP_DOWN, MODE_FILL.
  - SPEED_RESET=3, SPEED_MAX=7.
  - DIR_UP/DIR_DOWN.
- Sub-module btn_debounce_edge (parameter DEBOUNCE_BITS; ports clk, rst_n, btn, level, rise), instantiated three times.

Test Plan (N_LEDS=8, PWM_BITS=4, DIV_BITS=16, SPEED_SHIFT=4, TAIL=2, DEBOUNCE_BITS=2):
- Reset and pause:
  - Stimulus: reset, then hold all inputs low 2000 cycles.
  - Required: led_out shows only the head (LED0 at 15/16 duty, LED1 at 3/16); pos_out=0, speed_out=3, paused_out=1; pos never changes.
- Debounce:
  - Stimulus: btn_pause pulsed high 3 cycles, then again held high 10 cycles.
  - Required: the first pulse is ignored; the second toggles paused_out to 0 exactly once.
- Bounce timing:
  - Stimulus: unpaused, mode=00, speed 3 (period 512).
  - Required: pos sequence 0,1,…,7,6,…,0,1 with one step per 512 cycles; LED7 head with LED6 at duty 3/16 and LED5 at 0 (15>>4=0).
- Speed saturation and simultaneous edges:
  - Stimulus: 6 faster presses, then faster and slower pressed in the same cycle.
  - Required: speed_out 3→7 and stays 7; the simultaneous press leaves 7; tick period becomes 32 cycles.
- Wrap-down:
  - Stimulus: mode=10 with pos=0.
  - Required: next tick gives pos=7, then 6; tail on LED0 (3/16) when the head is at 7.
- Fill-bar and async reset:
  - Stimulus: mode=11 with pos=4; then assert rst_n mid-PWM-period.
  - Required: LEDs 0–4 are driven at FULL duty (15/16), LEDs 5–7 are 0; all outputs clear immediately on asserting rst_n, with no clock edge needed.

Source files
------------

// File: rtl/led_scanner_pkg.sv
// Shared constants for the LED scanner.
//   Mode encodings for the 2-bit mode input, speed-level limits,
//   and the sweep-direction type.
package led_scanner_pkg;

    localparam logic [1:0] MODE_BOUNCE    = 2'b00;
    localparam logic [1:0] MODE_WRAP_UP   = 2'b01;
    localparam logic [1:0] MODE_WRAP_DOWN = 2'b10;
    localparam logic [1:0] MODE_FILL      = 2'b11;

    localparam logic [2:0] SPEED_RESET = 3'd3;
    localparam logic [2:0] SPEED_MAX   = 3'd7;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/btn_debounce_edge.sv
// Button conditioner: 2-FF synchroniser, integrating debouncer and
// rising-edge pulse generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous button level
//   level      : debounced button level
//   rise       : one-cycle pulse on each rising edge of level
module btn_debounce_edge #(
    parameter int DEBOUNCE_BITS = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_level;
    logic                     r_rise;
    logic [DEBOUNCE_BITS-1:0] r_cnt;
    logic                     w_differs;
    logic                     w_expired;

    assign w_differs = (r_sync2 != r_level);
    // Counter at all-ones while still differing means this is the
    // 2^DEBOUNCE_BITS-th consecutive differing cycle.
    assign w_expired = &r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_expired) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_rise  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/led_scanner_pwm.sv
// LED light scanner with per-LED PWM brightness.
//   clk, rst_n         : clock, asynchronous active-low reset
//   btn_pause          : raw button, toggles pause/run
//   btn_faster/slower  : raw buttons, step the speed level up/down
//   mode               : 00 bounce, 01 wrap-up, 10 wrap-down, 11 fill-bar
//   led_out            : registered PWM drive, one bit per LED
//   pos_out            : head position
//   speed_out          : speed level 0..7
//   paused_out         : 1 while motion is paused
module led_scanner_pwm
    import led_scanner_pkg::*;
#(
    parameter int N_LEDS        = 8,
    parameter int PWM_BITS      = 8,
    parameter int DIV_BITS      = 35,
    parameter int SPEED_SHIFT   = 10,
    parameter int TAIL          = 2,
    parameter int DEBOUNCE_BITS = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_pause,
    input  logic                      btn_faster,
    input  logic                      btn_slower,
    input  logic [1:0]                mode,
    output logic [N_LEDS-1:0]         led_out,
    output logic [$clog2(N_LEDS)-1:0] pos_out,
    output logic [2:0]                speed_out,
    output logic                      paused_out
);

    localparam int                   POS_W    = $clog2(N_LEDS);
    localparam logic [POS_W-1:0]     LAST_POS = POS_W'(N_LEDS - 1);
    localparam logic [PWM_BITS-1:0]  FULL     = '1;

    logic [POS_W-1:0]    r_pos;
    dir_t                r_dir;
    logic [2:0]          r_speed;
    logic                r_paused;
    logic [DIV_BITS-1:0] r_acc;
    logic [PWM_BITS-1:0] r_pwm;
    logic [N_LEDS-1:0]   r_led;

    logic [2:0]          w_level;
    logic                w_pause_rise;
    logic                w_faster_rise;
    logic                w_slower_rise;
    logic [DIV_BITS:0]   w_step;
    logic [DIV_BITS:0]   w_sum;
    logic                w_tick;
    logic [POS_W-1:0]    w_pos_nxt;
    dir_t                w_dir_nxt;
    logic [PWM_BITS-1:0] w_bright [N_LEDS];

    // Saturating speed step; simultaneous up/down requests cancel.
    function automatic logic [2:0] next_speed(input logic [2:0] s,
                                              input logic up,
                                              input logic dn);
        if (up && !dn) return (s == SPEED_MAX) ? s : s + 3'd1;
        if (dn && !up) return (s == 3'd0) ? s : s - 3'd1;
        return s;
    endfunction

    // Brightness at distance d behind the head: each tail step is 4x dimmer.
    function automatic logic [PWM_BITS-1:0] tail_level(input int d);
        if (d == 0)    return FULL;
        if (d <= TAIL) return FULL >> (2 * d);
        return '0;
    endfunction

    function automatic logic [PWM_BITS-1:0] bright_for(input int led,
                                                       input int head,
                                                       input logic [1:0] m);
        int d;
        d = 0;
        if (m == MODE_FILL) begin
            return (led <= head) ? FULL : '0;
        end
        case (m)
            MODE_BOUNCE:  d = (led >= head) ? led - head : head - led;
            // Tail trails the head only, wrapping around the end of the strip.
            MODE_WRAP_UP: d = (head >= led) ? head - led : head + N_LEDS - led;
            default:      d = (led >= head) ? led - head : led + N_LEDS - head;
        endcase
        return tail_level(d);
    endfunction

    btn_debounce_edge #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_pause (
        .clk(clk), .rst_n(rst_n), .btn(btn_pause),  .level(w_level[0]), .rise(w_pause_rise)
    );
    btn_debounce_edge #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_faster (
        .clk(clk), .rst_n(rst_n), .btn(btn_faster), .level(w_level[1]), .rise(w_faster_rise)
    );
    btn_debounce_edge #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db_slower (
        .clk(clk), .rst_n(rst_n), .btn(btn_slower), .level(w_level[2]), .rise(w_slower_rise)
    );

    // Phase accumulator: the carry-out is the motion tick.
    assign w_step = (DIV_BITS + 1)'(1) << (SPEED_SHIFT + int'(r_speed));
    assign w_sum  = {1'b0, r_acc} + w_step;
    assign w_tick = w_sum[DIV_BITS];

    always_comb begin
        w_pos_nxt = r_pos;
        w_dir_nxt = r_dir;
        case (mode)
            MODE_BOUNCE: begin
                if (r_dir == DIR_UP) begin
                    if (r_pos == LAST_POS) begin
                        w_dir_nxt = DIR_DOWN;
                        w_pos_nxt = LAST_POS - 1'b1;
                    end else begin
                        w_pos_nxt = r_pos + 1'b1;
                    end
                end else begin
                    if (r_pos == '0) begin
                        w_dir_nxt = DIR_UP;
                        w_pos_nxt = POS_W'(1);
                    end else begin
                        w_pos_nxt = r_pos - 1'b1;
                    end
                end
            end
            MODE_WRAP_DOWN: begin
                w_dir_nxt = DIR_DOWN;
                w_pos_nxt = (r_pos == '0) ? LAST_POS : r_pos - 1'b1;
            end
            default: begin
                w_dir_nxt = DIR_UP;
                w_pos_nxt = (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            w_bright[i] = bright_for(i, int'(r_pos), mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos    <= '0;
            r_dir    <= DIR_UP;
            r_speed  <= SPEED_RESET;
            r_paused <= 1'b1;
            r_acc    <= '0;
            r_pwm    <= '0;
            r_led    <= '0;
        end else begin
            r_acc   <= w_sum[DIV_BITS-1:0];
            r_pwm   <= r_pwm + 1'b1;
            r_speed <= next_speed(r_speed, w_faster_rise, w_slower_rise);
            if (w_pause_rise) r_paused <= ~r_paused;
            if (w_tick && !r_paused) begin
                r_pos <= w_pos_nxt;
                r_dir <= w_dir_nxt;
            end
            // Brightness compare result is registered: one cycle of latency.
            for (int i = 0; i < N_LEDS; i++) begin
                r_led[i] <= (r_pwm < w_bright[i]);
            end
        end
    end

    assign led_out    = r_led;
    assign pos_out    = r_pos;
    assign speed_out  = r_speed;
    assign paused_out = r_paused;

endmodule

// File: tb/tb_led_scanner_pwm.sv
module tb_led_scanner_pwm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_faster = 1'b0;
    logic       btn_slower = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] led_out;
    logic [2:0] pos_out;
    logic [2:0] speed_out;
    logic       paused_out;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    int duty [8];

    led_scanner_pwm #(
        .N_LEDS(8), .PWM_BITS(4), .DIV_BITS(16), .SPEED_SHIFT(4),
        .TAIL(2), .DEBOUNCE_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_pause(btn_pause), .btn_faster(btn_faster),
        .btn_slower(btn_slower), .mode(mode), .led_out(led_out), .pos_out(pos_out),
        .speed_out(speed_out), .paused_out(paused_out)
    );

    always #5 clk = ~clk;

    // Active clock edges since reset release; ticks land on multiples of 512 at speed 3.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic measure_duty();
        for (int i = 0; i < 8; i++) duty[i] = 0;
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) duty[i] += int'(led_out[i]);
        end
    endtask

    task automatic wait_change(input int limit, output bit ok);
        logic [2:0] prev;
        int k;
        prev = pos_out;
        ok = 1'b0;
        k = 0;
        while (!ok && k < limit) begin
            @(negedge clk);
            k++;
            if (pos_out !== prev) ok = 1'b1;
        end
    endtask

    task automatic wait_for_pos(input logic [2:0] target, output bit ok);
        bit got;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 20) begin
            wait_change(100, got);
            n++;
            if (got && pos_out === target) ok = 1'b1;
        end
    endtask

    task automatic press(input bit p, input bit f, input bit s);
        @(negedge clk);
        btn_pause = p; btn_faster = f; btn_slower = s;
        repeat (10) @(negedge clk);
        btn_pause = 1'b0; btn_faster = 1'b0; btn_slower = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        int moved;
        int exp_duty [8];
        exp_duty = '{15, 3, 0, 0, 0, 0, 0, 0};
        rst_n = 1'b0;
        mode = 2'b00;
        repeat (3) @(negedge clk);
        n_checks++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h expected 00", led_out); end
        n_checks++; if (pos_out !== 3'd0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", pos_out); end
        n_checks++; if (speed_out !== 3'd3) begin n_fail++; $display("FAIL reset_speed: got %0d expected 3", speed_out); end
        n_checks++; if (paused_out !== 1'b1) begin n_fail++; $display("FAIL reset_paused: got %0d expected 1", paused_out); end
        rst_n = 1'b1;
        moved = 0;
        repeat (2000) begin
            @(negedge clk);
            if (pos_out !== 3'd0) moved++;
        end
        n_checks++; if (moved !== 0) begin n_fail++; $display("FAIL paused_hold: pos moved in %0d cycles, expected 0", moved); end
        measure_duty();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (duty[i] !== exp_duty[i]) begin
                n_fail++; $display("FAIL reset_duty led%0d: got %0d/16 expected %0d/16", i, duty[i], exp_duty[i]);
            end
        end
    endtask

    task automatic test_debounce();
        int toggles;
        logic last;
        @(negedge clk);
        btn_pause = 1'b1;
        repeat (3) @(negedge clk);
        btn_pause = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (paused_out !== 1'b1) begin n_fail++; $display("FAIL short_pulse: paused %0d expected 1", paused_out); end
        // Unpause well clear of the next motion tick.
        while (cyc % 512 != 100) @(negedge clk);
        toggles = 0;
        last = paused_out;
        btn_pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (paused_out !== last) toggles++;
            last = paused_out;
        end
        btn_pause = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (paused_out !== last) toggles++;
            last = paused_out;
        end
        n_checks++; if (paused_out !== 1'b0) begin n_fail++; $display("FAIL long_press: paused %0d expected 0", paused_out); end
        n_checks++; if (toggles !== 1) begin n_fail++; $display("FAIL toggle_count: got %0d expected 1", toggles); end
    endtask

    task automatic test_bounce();
        int exp_seq [15];
        int last_cyc;
        bit ok;
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        last_cyc = 0;
        mode = 2'b00;
        for (int j = 0; j < 15; j++) begin
            wait_change(600, ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL bounce_timeout step%0d: no move, expected pos %0d", j, exp_seq[j]);
            end else if (int'(pos_out) !== exp_seq[j]) begin
                n_fail++; $display("FAIL bounce_pos step%0d: got %0d expected %0d", j, pos_out, exp_seq[j]);
            end
            if (j > 0) begin
                n_checks++;
                if (cyc - last_cyc !== 512) begin
                    n_fail++; $display("FAIL bounce_period step%0d: got %0d expected 512", j, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            if (j == 6) begin
                @(negedge clk);
                measure_duty();
                n_checks++; if (duty[7] !== 15) begin n_fail++; $display("FAIL bounce_head7: got %0d expected 15", duty[7]); end
                n_checks++; if (duty[6] !== 3) begin n_fail++; $display("FAIL bounce_tail6: got %0d expected 3", duty[6]); end
                n_checks++; if (duty[5] !== 0) begin n_fail++; $display("FAIL bounce_tail5: got %0d expected 0", duty[5]); end
            end
        end
    endtask

    task automatic test_speed();
        int exp_speed [6];
        int last_cyc;
        bit ok;
        exp_speed = '{4, 5, 6, 7, 7, 7};
        for (int k = 0; k < 6; k++) begin
            press(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (int'(speed_out) !== exp_speed[k]) begin
                n_fail++; $display("FAIL faster_press%0d: got %0d expected %0d", k, speed_out, exp_speed[k]);
            end
        end
        press(1'b0, 1'b1, 1'b1);
        n_checks++; if (speed_out !== 3'd7) begin n_fail++; $display("FAIL simultaneous: got %0d expected 7", speed_out); end
        wait_change(100, ok);
        last_cyc = cyc;
        wait_change(100, ok);
        n_checks++;
        if (!ok || (cyc - last_cyc) !== 32) begin
            n_fail++; $display("FAIL fast_period: got %0d expected 32", cyc - last_cyc);
        end
    endtask

    task automatic test_wrap_down();
        bit ok;
        mode = 2'b10;
        wait_for_pos(3'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrapdn_reach0: pos %0d expected 0", pos_out); end
        wait_change(100, ok);
        n_checks++; if (pos_out !== 3'd7) begin n_fail++; $display("FAIL wrapdn_wrap: got %0d expected 7", pos_out); end
        @(negedge clk);
        measure_duty();
        n_checks++; if (duty[7] !== 15) begin n_fail++; $display("FAIL wrapdn_head7: got %0d expected 15", duty[7]); end
        n_checks++; if (duty[0] !== 3) begin n_fail++; $display("FAIL wrapdn_tail0: got %0d expected 3", duty[0]); end
        n_checks++; if (duty[6] !== 0) begin n_fail++; $display("FAIL wrapdn_ahead6: got %0d expected 0", duty[6]); end
        wait_change(100, ok);
        n_checks++; if (pos_out !== 3'd6) begin n_fail++; $display("FAIL wrapdn_next: got %0d expected 6", pos_out); end
    endtask

    task automatic test_fill_reset();
        bit ok;
        bit seen;
        int k;
        mode = 2'b11;
        wait_for_pos(3'd4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fill_reach4: pos %0d expected 4", pos_out); end
        @(negedge clk);
        measure_duty();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (duty[i] !== ((i <= 4) ? 15 : 0)) begin
                n_fail++; $display("FAIL fill_duty led%0d: got %0d expected %0d", i, duty[i], (i <= 4) ? 15 : 0);
            end
        end
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (led_out === 8'h1F) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL fill_pattern: got %h expected 1f", led_out); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL async_led: got %h expected 00", led_out); end
        n_checks++; if (pos_out !== 3'd0) begin n_fail++; $display("FAIL async_pos: got %0d expected 0", pos_out); end
        n_checks++; if (speed_out !== 3'd3) begin n_fail++; $display("FAIL async_speed: got %0d expected 3", speed_out); end
        n_checks++; if (paused_out !== 1'b1) begin n_fail++; $display("FAIL async_paused: got %0d expected 1", paused_out); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_bounce();
        test_speed();
        test_wrap_down();
        test_fill_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
